player_input: RTL and testbench

PLAYER_INPUT -- requirements
Module: player_input

---
 rtl/player_input.sv | 155 +++++++++++++++
 tb/tb_player_input.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/player_input.sv
// Player input front end: synchronizes and debounces the 3x3 pad, start and super buttons,
// and runs the super-mode timer/charge FSM on the debounce strobe.
module player_input #(
    parameter int PRESCALE      = 100000,
    parameter int DEB_SAMPLES   = 4,
    parameter int SUPER_LEN     = 2000,
    parameter int COOL_LEN      = 1000,
    parameter int SUPER_CHARGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] btn_raw,
    input  logic       start_raw,
    input  logic       super_raw,
    input  logic [1:0] game_state,
    output logic [8:0] box,
    output logic       start,
    output logic       super_mode,
    output logic [1:0] super_left
);

    localparam int NIN = 11;
    localparam int PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int FW  = $clog2(DEB_SAMPLES + 1);
    localparam logic [1:0] GS_INIT = 2'b00;
    localparam logic [1:0] GS_PLAY = 2'b01;

    typedef enum logic [1:0] {READY, ACTIVE, COOL} super_state_t;

    logic [NIN-1:0]         raw, sync1, sync2, deb, all1, all0;
    logic [DEB_SAMPLES-1:0] hist [NIN];
    logic [PW-1:0]          pre_cnt;
    logic                   strobe;
    logic [FW-1:0]          fill_cnt;
    logic                   fill_done;
    logic [1:0]             armed;
    logic                   start_rise, super_rise, play;

    super_state_t state_q, state_n;
    logic [11:0]  timer_q, timer_n;
    logic [1:0]   left_q, left_n;

    assign raw       = {super_raw, start_raw, btn_raw};
    assign strobe    = (pre_cnt == PW'(PRESCALE - 1));
    assign fill_done = (fill_cnt == FW'(DEB_SAMPLES));
    assign box       = deb[8:0];
    assign super_left = left_q;
    assign play      = (game_state == GS_PLAY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            pre_cnt <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            pre_cnt <= strobe ? '0 : pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NIN; i++) hist[i] <= '0;
        end else if (strobe) begin
            for (int unsigned i = 0; i < NIN; i++)
                hist[i] <= (hist[i] << 1) | DEB_SAMPLES'(sync2[i]);
        end
    end

    always_comb begin
        all1 = '0;
        all0 = '0;
        for (int unsigned i = 0; i < NIN; i++) begin
            all1[i] = &hist[i];
            all0[i] = ~|hist[i];
        end
    end

    // Start/super edges only count once a genuinely low history has been seen,
    // so buttons held through reset release never fire.
    assign start_rise = all1[9]  & ~deb[9]  & armed[0];
    assign super_rise = all1[10] & ~deb[10] & armed[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb      <= '0;
            fill_cnt <= '0;
            armed    <= '0;
            start    <= 1'b0;
        end else begin
            deb   <= all1 | (deb & ~all0);
            start <= start_rise;
            armed <= armed | ({all0[10], all0[9]} & {2{fill_done}});
            if (strobe && !fill_done) fill_cnt <= fill_cnt + FW'(1);
        end
    end

    always_comb begin
        state_n = state_q;
        timer_n = timer_q;
        left_n  = left_q;
        case (state_q)
            READY: begin
                if (super_rise && play && left_q != 2'd0) begin
                    state_n = ACTIVE;
                    left_n  = left_q - 2'd1;
                    timer_n = 12'(SUPER_LEN - 1);
                end
            end
            ACTIVE: begin
                if (!play) begin
                    state_n = READY;
                    timer_n = '0;
                end else if (strobe) begin
                    if (timer_q == 12'd0) begin
                        state_n = COOL;
                        timer_n = 12'(COOL_LEN - 1);
                    end else begin
                        timer_n = timer_q - 12'd1;
                    end
                end
            end
            COOL: begin
                if (!play) begin
                    state_n = READY;
                    timer_n = '0;
                end else if (strobe) begin
                    if (timer_q == 12'd0) state_n = READY;
                    else                  timer_n = timer_q - 12'd1;
                end
            end
            default: begin
                state_n = READY;
                timer_n = '0;
            end
        endcase
        if (game_state == GS_INIT) left_n = 2'(SUPER_CHARGES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= READY;
            timer_q    <= '0;
            left_q     <= 2'(SUPER_CHARGES);
            super_mode <= 1'b0;
        end else begin
            state_q    <= state_n;
            timer_q    <= timer_n;
            left_q     <= left_n;
            super_mode <= (state_n == ACTIVE);
        end
    end

endmodule

// File: tb/tb_player_input.sv
// Directed bench for player_input with a small prescaler: debounce, start pulse,
// super-mode charges/timing, game-state aborts and asynchronous reset.
module tb_player_input;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] btn_raw;
    logic       start_raw;
    logic       super_raw;
    logic [1:0] game_state;
    logic [8:0] box;
    logic       start;
    logic       super_mode;
    logic [1:0] super_left;

    int n_pass  = 0;
    int n_total = 0;

    player_input #(
        .PRESCALE(4),
        .DEB_SAMPLES(4),
        .SUPER_LEN(8),
        .COOL_LEN(4),
        .SUPER_CHARGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .start_raw(start_raw),
        .super_raw(super_raw),
        .game_state(game_state),
        .box(box),
        .start(start),
        .super_mode(super_mode),
        .super_left(super_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for super_mode to reach a level; a timeout shows up as a failed check.
    task automatic wait_super(input logic level, input int bound, input string tag);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (super_mode == level) break;
        end
        check(tag, super_mode, level);
    endtask

    initial begin
        int pulses, width, cur, n, bad, hi;

        rst = 1'b1; btn_raw = '0; start_raw = 1'b1; super_raw = 1'b0; game_state = 2'b00;
        tick(3);
        check("rst_box", box, 0);
        check("rst_start", start, 0);
        check("rst_super", super_mode, 0);
        check("rst_left", super_left, 2);

        // start held high across reset release must not pulse
        rst = 1'b0;
        pulses = 0;
        repeat (40) begin @(negedge clk); if (start) pulses++; end
        check("start_held_from_rst", pulses, 0);
        start_raw = 1'b0;
        tick(30);

        btn_raw = 9'h010;
        n = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (box == 9'h010) begin n = i; break; end
        end
        check("box_set", box, 9'h010);
        check("box_latency", (n > 0 && n <= 22), 1);

        btn_raw = 9'h000; tick(4); btn_raw = 9'h010;
        bad = 0;
        repeat (30) begin @(negedge clk); if (box != 9'h010) bad++; end
        check("glitch_ignored", bad, 0);

        btn_raw = 9'h1A5; tick(25);
        check("box_pattern", box, 9'h1A5);
        btn_raw = 9'h000; tick(25);
        check("box_clear", box, 0);

        start_raw = 1'b1;
        pulses = 0; width = 0; cur = 0;
        repeat (100) begin
            @(negedge clk);
            if (start) begin
                cur++;
                if (cur == 1) pulses++;
                if (cur > width) width = cur;
            end else cur = 0;
        end
        check("start_pulses", pulses, 1);
        check("start_width", width, 1);
        start_raw = 1'b0; tick(30);

        game_state = 2'b01; tick(2);
        check("left_before", super_left, 2);
        super_raw = 1'b1;
        wait_super(1'b1, 30, "super_on_1");
        check("left_after_1", super_left, 1);
        hi = 0;
        for (int k = 0; k < 80; k++) begin
            if (k == 0)  super_raw = 1'b0;
            if (k == 22) super_raw = 1'b1;
            if (k == 60) super_raw = 1'b0;
            if (super_mode) hi++;
            @(negedge clk);
        end
        check("super_len", (hi >= 28 && hi <= 36), 1);
        check("left_press_ignored", super_left, 1);
        check("super_off_1", super_mode, 0);
        tick(10);

        super_raw = 1'b1;
        wait_super(1'b1, 30, "super_on_2");
        check("left_after_2", super_left, 0);
        super_raw = 1'b0;
        wait_super(1'b0, 60, "super_off_2");
        tick(30);
        super_raw = 1'b1;
        hi = 0;
        repeat (40) begin @(negedge clk); if (super_mode) hi++; end
        check("third_press_ignored", hi, 0);
        check("left_zero", super_left, 0);
        super_raw = 1'b0; tick(25);

        game_state = 2'b00; tick(2);
        check("init_reload", super_left, 2);
        game_state = 2'b01; tick(2);

        super_raw = 1'b1;
        wait_super(1'b1, 30, "super_on_3");
        super_raw = 1'b0; tick(5);
        game_state = 2'b10; tick(2);
        check("finish_drop", super_mode, 0);
        game_state = 2'b01;
        hi = 0;
        repeat (10) begin @(negedge clk); if (super_mode) hi++; end
        check("ready_after_finish", hi, 0);
        check("left_after_3", super_left, 1);
        tick(25);

        btn_raw = 9'h010; super_raw = 1'b1;
        wait_super(1'b1, 30, "super_on_4");
        tick(3);
        check("box_before_rst", box, 9'h010);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_async_super", super_mode, 0);
        check("rst_async_box", box, 0);
        check("rst_async_left", super_left, 2);
        rst = 1'b0; btn_raw = '0; super_raw = 1'b0;
        tick(5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
